// File: rtl/tt_proj_mux_ctrl_if.sv
// Wrapper-side bus of the project-select controller: the broadcast input
// bundle, the one-hot enables and the concatenated wrapper output bundles.
interface tt_proj_mux_ctrl_if #(
  parameter int N_PROJ = 8
);

  // {uio_in, ui_in, rst_n, clk} broadcast to every wrapper
  logic [17:0]            iw;
  // one-hot project enable
  logic [N_PROJ-1:0]      ena;
  // project k drives bits [24k+23:24k] as {uio_oe, uio_out, uo_out}
  logic [24*N_PROJ-1:0]   ow_all;

  // controller side
  modport master (
    output iw,
    output ena,
    input  ow_all
  );

  // wrapper side
  modport slave (
    input  iw,
    input  ena,
    output ow_all
  );

endinterface

// File: rtl/tt_proj_mux_ctrl.sv
// Project-select controller. Broadcasts the pad inputs to every wrapper,
// drives a one-hot enable, and returns the selected wrapper's outputs to the
// pads. Every switch is break-before-make: all projects off for GAP_CYCLES,
// then the new project held in reset for RST_CYCLES before its outputs are
// released to the pads.
module tt_proj_mux_ctrl #(
  parameter int N_PROJ     = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel_load,
  input  logic [ADDR_W-1:0]   sel_addr,
  input  logic [7:0]          pad_ui_in,
  input  logic [7:0]          pad_uio_in,
  input  logic                pad_user_rst_n,
  tt_proj_mux_ctrl_if.master  wrap,
  output logic [7:0]          pad_uo_out,
  output logic [7:0]          pad_uio_out,
  output logic [7:0]          pad_uio_oe,
  output logic [ADDR_W-1:0]   cur_sel,
  output logic                sel_valid,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // one shared counter times both the GAP and HOLD phases
  localparam int CNT_MAX = (GAP_CYCLES > RST_CYCLES) ? GAP_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  LP_GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_RST_LAST = CNT_W'(RST_CYCLES - 1);
  // one extra bit so N_PROJ == 2^ADDR_W is still representable
  localparam logic [ADDR_W:0]   LP_N_PROJ   = (ADDR_W + 1)'(N_PROJ);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [ADDR_W-1:0]    r_cur_sel;
  logic                 r_sel_valid;
  logic [N_PROJ-1:0]    r_ena;
  logic                 r_busy;
  logic                 r_run;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [ADDR_W-1:0]    w_sel_nxt;
  logic                 w_valid_nxt;
  logic [N_PROJ-1:0]    w_ena_nxt;
  logic                 w_busy_nxt;
  logic                 w_run_nxt;
  logic [23:0]          w_ow_sel;
  logic                 w_proj_rst_n;

  // Decode a project index into its one-hot enable pattern.
  function automatic logic [N_PROJ-1:0] f_onehot(input logic [ADDR_W-1:0] idx);
    logic [N_PROJ-1:0] v;
    v = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (idx == ADDR_W'(k)) begin
        v[k] = 1'b1;
      end else begin
        v[k] = 1'b0;
      end
    end
    return v;
  endfunction

  // Next-state, select latch and phase counter; a load always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_cur_sel;
    w_valid_nxt = r_sel_valid;
    if (sel_load) begin
      w_sel_nxt   = sel_addr;
      w_valid_nxt = ({1'b0, sel_addr} < LP_N_PROJ);
      w_state_nxt = ST_GAP;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
        end
        ST_GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = r_sel_valid ? ST_HOLD : ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_cnt == LP_RST_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so ena/busy/gating land with the state.
  always_comb begin
    w_ena_nxt  = '0;
    w_busy_nxt = 1'b0;
    w_run_nxt  = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_ena_nxt = '0;
      end
      ST_GAP: begin
        w_busy_nxt = 1'b1;
      end
      ST_HOLD: begin
        w_busy_nxt = 1'b1;
        if (w_valid_nxt) begin
          w_ena_nxt = f_onehot(w_sel_nxt);
        end else begin
          w_ena_nxt = '0;
        end
      end
      ST_RUN: begin
        if (w_valid_nxt) begin
          w_ena_nxt = f_onehot(w_sel_nxt);
          w_run_nxt = 1'b1;
        end else begin
          w_ena_nxt = '0;
          w_run_nxt = 1'b0;
        end
      end
      default: begin
        w_ena_nxt = '0;
      end
    endcase
  end

  // State, selection and registered output flags; async reset drops ena at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cur_sel   <= '0;
      r_sel_valid <= 1'b0;
      r_ena       <= '0;
      r_busy      <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur_sel   <= w_sel_nxt;
      r_sel_valid <= w_valid_nxt;
      r_ena       <= w_ena_nxt;
      r_busy      <= w_busy_nxt;
      r_run       <= w_run_nxt;
    end
  end

  // Pick the selected wrapper's output bundle; no register so video timing holds.
  always_comb begin
    w_ow_sel = 24'h000000;
    for (int k = 0; k < N_PROJ; k++) begin
      if (r_cur_sel == ADDR_W'(k)) begin
        w_ow_sel = wrap.ow_all[k*24 +: 24];
      end else begin
        w_ow_sel = w_ow_sel;
      end
    end
  end

  // Pads are blanked (and bidirectionals tri-stated) unless the project runs.
  always_comb begin
    if (r_run) begin
      pad_uo_out  = w_ow_sel[7:0];
      pad_uio_out = w_ow_sel[15:8];
      pad_uio_oe  = w_ow_sel[23:16];
    end else begin
      pad_uo_out  = 8'h00;
      pad_uio_out = 8'h00;
      pad_uio_oe  = 8'h00;
    end
  end

  // The project sees reset until it is released into RUN.
  assign w_proj_rst_n = r_run ? pad_user_rst_n : 1'b0;

  assign wrap.iw    = {pad_uio_in, pad_ui_in, w_proj_rst_n, clk};
  assign wrap.ena   = r_ena;
  assign cur_sel    = r_cur_sel;
  assign sel_valid  = r_sel_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Directed bench for tt_proj_mux_ctrl: an 8-project instance for the main
// sequences and a 6-project instance for out-of-range selection.
module tb_tt_proj_mux_ctrl;

  localparam int GAP = 2;
  localparam int RST = 4;

  logic         clk;
  logic         rst_n;
  logic         sel_load;
  logic [2:0]   sel_addr;
  logic [7:0]   pad_ui_in;
  logic [7:0]   pad_uio_in;
  logic         pad_user_rst_n;
  logic [191:0] ow8;

  logic [7:0]   uo8, uio8, oe8;
  logic [2:0]   cs8;
  logic         sv8, busy8;
  logic [7:0]   uo6, uio6, oe6;
  logic [2:0]   cs6;
  logic         sv6, busy6;

  int n_vec;
  int n_err;

  tt_proj_mux_ctrl_if #(.N_PROJ(8)) bus8 ();
  tt_proj_mux_ctrl_if #(.N_PROJ(6)) bus6 ();

  assign bus8.ow_all = ow8;
  assign bus6.ow_all = ow8[143:0];

  tt_proj_mux_ctrl #(.N_PROJ(8), .ADDR_W(3), .GAP_CYCLES(GAP), .RST_CYCLES(RST)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sel_load(sel_load), .sel_addr(sel_addr),
    .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in), .pad_user_rst_n(pad_user_rst_n),
    .wrap(bus8), .pad_uo_out(uo8), .pad_uio_out(uio8), .pad_uio_oe(oe8),
    .cur_sel(cs8), .sel_valid(sv8), .busy(busy8)
  );

  tt_proj_mux_ctrl #(.N_PROJ(6), .ADDR_W(3), .GAP_CYCLES(GAP), .RST_CYCLES(RST)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .sel_load(sel_load), .sel_addr(sel_addr),
    .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in), .pad_user_rst_n(pad_user_rst_n),
    .wrap(bus6), .pad_uo_out(uo6), .pad_uio_out(uio6), .pad_uio_oe(oe6),
    .cur_sel(cs6), .sel_valid(sv6), .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a);
    sel_addr = a;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
  endtask

  // Walk a freshly loaded valid selection through GAP, HOLD and into RUN.
  // Called one cycle after the load edge; project k drives uo=0x50+k,
  // uio_out=0x20+k, uio_oe=0xC0|k.
  task automatic seq_check(input logic [2:0] a, input int ncyc);
    logic [7:0] oh;
    logic [7:0] exp_ena;
    logic       live;
    oh = 8'h01 << a;
    for (int c = 1; c <= ncyc; c++) begin
      exp_ena = (c > GAP) ? oh : 8'h00;
      live    = (c > GAP + RST);
      check_eq($sformatf("ena_p%0d_c%0d", a, c), {24'h0, bus8.ena}, {24'h0, exp_ena});
      check_eq($sformatf("busy_p%0d_c%0d", a, c), {31'h0, busy8}, {31'h0, !live});
      check_eq($sformatf("iw1_p%0d_c%0d", a, c), {31'h0, bus8.iw[1]}, {31'h0, live});
      check_eq($sformatf("uo_p%0d_c%0d", a, c), {24'h0, uo8},
               live ? {24'h0, 8'h50 + 8'(a)} : 32'h0);
      check_eq($sformatf("uio_p%0d_c%0d", a, c), {24'h0, uio8},
               live ? {24'h0, 8'h20 + 8'(a)} : 32'h0);
      check_eq($sformatf("oe_p%0d_c%0d", a, c), {24'h0, oe8},
               live ? {24'h0, 8'hC0 | 8'(a)} : 32'h0);
      if (c < ncyc) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sel_load = 1'b0;
    sel_addr = 3'd0;
    pad_ui_in = 8'h00;
    pad_uio_in = 8'h00;
    pad_user_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ow8[k*24 +: 24] = {8'hC0 | 8'(k), 8'h20 + 8'(k), 8'h50 + 8'(k)};
    end

    // reset state
    tick();
    check_eq("rst_ena", {24'h0, bus8.ena}, 32'h0);
    check_eq("rst_busy", {31'h0, busy8}, 32'h0);
    check_eq("rst_cur_sel", {29'h0, cs8}, 32'h0);
    check_eq("rst_sel_valid", {31'h0, sv8}, 32'h0);
    check_eq("rst_oe", {24'h0, oe8}, 32'h0);
    check_eq("rst_iw1", {31'h0, bus8.iw[1]}, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("idle_ena", {24'h0, bus8.ena}, 32'h0);
    check_eq("idle_busy", {31'h0, busy8}, 32'h0);

    // project 3 from IDLE
    load(3'd3);
    check_eq("p3_cur_sel", {29'h0, cs8}, 32'h3);
    check_eq("p3_sel_valid", {31'h0, sv8}, 32'h1);
    seq_check(3'd3, 7);
    pad_user_rst_n = 1'b0;
    #1;
    check_eq("run_user_rst_lo", {31'h0, bus8.iw[1]}, 32'h0);
    pad_user_rst_n = 1'b1;
    #1;
    check_eq("run_user_rst_hi", {31'h0, bus8.iw[1]}, 32'h1);

    // iw pass-through is combinational
    pad_ui_in = 8'hA5;
    pad_uio_in = 8'h3C;
    #1;
    check_eq("iw_ui", {24'h0, bus8.iw[9:2]}, 32'hA5);
    check_eq("iw_uio", {24'h0, bus8.iw[17:10]}, 32'h3C);
    check_eq("iw_clk", {31'h0, bus8.iw[0]}, 32'h1);

    // switch 3 -> 5
    load(3'd5);
    check_eq("p5_cur_sel", {29'h0, cs8}, 32'h5);
    seq_check(3'd5, 7);

    // switch to 2, interrupted twice by loads of 7 during HOLD
    load(3'd2);
    tick();
    tick();
    check_eq("p2_hold_ena", {24'h0, bus8.ena}, 32'h04);
    load(3'd7);
    check_eq("p7a_ena_after_p2", {24'h0, bus8.ena}, 32'h0);
    check_eq("iw_fwd_gap", {24'h0, bus8.iw[9:2]}, 32'hA5);
    tick();
    tick();
    tick();
    check_eq("p7a_hold_ena", {24'h0, bus8.ena}, 32'h80);
    load(3'd7);
    seq_check(3'd7, 7);
    check_eq("p7_final_ena", {24'h0, bus8.ena}, 32'h80);

    // out-of-range selection on the 6-project instance
    load(3'd6);
    check_eq("oor_sel_valid", {31'h0, sv6}, 32'h0);
    check_eq("oor_cur_sel", {29'h0, cs6}, 32'h6);
    for (int c = 1; c <= 6; c++) begin
      check_eq($sformatf("oor_ena_c%0d", c), {26'h0, bus6.ena}, 32'h0);
      check_eq($sformatf("oor_busy_c%0d", c), {31'h0, busy6}, (c <= GAP) ? 32'h1 : 32'h0);
      check_eq($sformatf("oor_uo_c%0d", c), {24'h0, uo6}, 32'h0);
      check_eq($sformatf("oor_oe_c%0d", c), {24'h0, oe6}, 32'h0);
      tick();
    end

    // asynchronous reset mid-RUN on project 7 driving uio_oe=FF
    ow8[7*24+16 +: 8] = 8'hFF;
    load(3'd7);
    for (int c = 2; c <= 7; c++) tick();
    check_eq("pre_rst_oe", {24'h0, oe8}, 32'hFF);
    check_eq("pre_rst_ena", {24'h0, bus8.ena}, 32'h80);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ena", {24'h0, bus8.ena}, 32'h0);
    check_eq("async_rst_oe", {24'h0, oe8}, 32'h0);
    check_eq("async_rst_busy", {31'h0, busy8}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_eq("post_rst_ena", {24'h0, bus8.ena}, 32'h0);
    check_eq("post_rst_busy", {31'h0, busy8}, 32'h0);
    check_eq("post_rst_oe", {24'h0, oe8}, 32'h0);
    check_eq("post_rst_cur_sel", {29'h0, cs8}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_proj_mux_ctrl.md
Name: tt_proj_mux_ctrl

Overview:
- Project-select controller that sits directly upstream and downstream of the per-project wrappers.
- Broadcasts the 18-bit pad input bundle `iw` ({uio_in, ui_in, rst_n, clk}) to all wrappers and drives the one-hot `ena` vector.
- Returns the selected wrapper's 24-bit `ow` bundle ({uio_oe, uio_out, uo_out}) to the pads.
- Every project switch runs break-before-make: all projects disabled for a gap, then the new project held in reset for a fixed count before its outputs reach the pads.

Parameters:
- N_PROJ, 8, number of attached wrappers.
- ADDR_W, 3, select address width; 2^ADDR_W >= N_PROJ.
- GAP_CYCLES, 2, cycles with all ena low between projects (>= 1).
- RST_CYCLES, 4, cycles the new project sees rst_n=0 after ena rises (>= 1).

Ports:
- clk  input  1  system clock; also forwarded as iw[0].
- rst_n  input  1  asynchronous active-low reset.
- sel_load  input  1  one-cycle strobe; latch sel_addr as new selection.
- sel_addr  input  ADDR_W  requested project index.
- pad_ui_in  input  8  dedicated input pads.
- pad_uio_in  input  8  bidirectional pad input values.
- pad_user_rst_n  input  1  user reset pad, active-low.
- iw  output  18  bundle to all wrappers: {pad_uio_in, pad_ui_in, proj_rst_n, clk}.
- ena  output  N_PROJ  one-hot project enable.
- ow_all  input  24*N_PROJ  concatenated wrapper outputs; project k occupies bits [24k+23:24k].
- pad_uo_out  output  8  dedicated output pads.
- pad_uio_out  output  8  bidirectional output values.
- pad_uio_oe  output  8  bidirectional output enables (1 = drive).
- cur_sel  output  ADDR_W  currently latched selection.
- sel_valid  output  1  latched selection is in range (< N_PROJ).
- busy  output  1  high in GAP or HOLD.

Behaviour:

Reset values:
- Async assert of rst_n: state=IDLE, cur_sel=0, sel_valid=0, ena=0, all counters 0.
- pad_uo_out=0, pad_uio_out=0, pad_uio_oe=0, busy=0.
- Deassertion is taken synchronously at the next clk edge.

States:
- IDLE: ena=0, pads blanked. sel_load -> GAP.
- GAP: ena=0, pads blanked. Counter runs GAP_CYCLES cycles, then:
  - to HOLD if sel_valid;
  - to IDLE otherwise.
- HOLD: ena = one-hot(cur_sel). iw[1]=0. Pads blanked. After RST_CYCLES cycles -> RUN.
- RUN: ena = one-hot(cur_sel). iw[1]=pad_user_rst_n. Pads = ow_all slice of cur_sel. sel_load -> GAP.

Select latch:
- On sel_load in any state, at that edge: cur_sel <= sel_addr, sel_valid <= (sel_addr < N_PROJ), state <= GAP, gap counter cleared.
- Latest load wins: sel_load during GAP or HOLD restarts the sequence at GAP cycle 0, and ena drops on the next cycle.
- Out-of-range selection: GAP, then IDLE; ena stays 0.
- Reloading the same index still performs the full GAP/HOLD sequence. This is the software soft-reset path.

Outputs and timing:
- ena, busy and the pad-gating state are registered.
- The ow_all -> pad path and the clk/pad -> iw path are combinational (no added latency, so project video timing is preserved).
- iw[17:2] is always forwarded unmodified, including in IDLE and GAP.
- Blanked pads mean uo_out=0, uio_out=0, uio_oe=0; all bidirectional pads are high-Z.
- busy = (state==GAP) or (state==HOLD).
- Timing from a sel_load at edge E:
  - ena low from E+1 through E+GAP_CYCLES;
  - ena high from E+GAP_CYCLES+1;
  - pads live from E+GAP_CYCLES+RST_CYCLES+1.
- Reset mid-sequence: ena drops immediately (asynchronously) and the block returns to IDLE.
- At most one ena bit is high in any cycle, and no two different projects are enabled in adjacent cycles.

Test Plan:
- Reset, then sel_load with sel_addr=3, GAP=2, RST=4 → ena=0 for 2 cycles; ena=8'h08 with iw[1]=0 for 4 cycles; then iw[1]=pad_user_rst_n and pad_uo_out equals ow_all[79:72].
- In RUN on project 3, sel_load with sel_addr=5 → ena goes 8'h08 → 0 (2 cycles) → 8'h20. Pads are 0 throughout GAP and HOLD. busy is high for exactly 6 cycles.
- sel_load with sel_addr=7 during HOLD of project 2, then a second load with sel_addr=7 → sequence restarts each time. ena never shows 8'h04 and 8'h80 back-to-back. Final ena=8'h80.
- N_PROJ=6, sel_addr=6 → sel_valid=0. After GAP the state is IDLE; ena stays 0, pads stay 0, busy drops.
- Assert rst_n low mid-RUN, with ow_all driving uio_oe=8'hFF → ena and pad_uio_oe go to 0 asynchronously, before the next clk edge. After release the block stays in IDLE.
- In RUN, toggle pad_ui_in=8'hA5 and pad_uio_in=8'h3C → iw[9:2]=8'hA5 and iw[17:10]=8'h3C in the same cycle; no register delay.
